// File: rtl/vga_pkg.sv
// Shared types for the VGA pixel prefetch slice.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } vga_state_e;

endpackage

// File: rtl/vga_pixel_fifo.sv
// First-word fall-through pixel FIFO with occupancy count and synchronous flush.
module vga_pixel_fifo #(
  parameter int BIT_DEPTH = 8,
  parameter int DEPTH     = 16
) (
  input  logic                       vclk,
  input  logic                       srst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [BIT_DEPTH-1:0]       din,
  input  logic                       pop,
  output logic [BIT_DEPTH-1:0]       dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [BIT_DEPTH-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        cnt;
  logic                 do_pop;

  assign empty  = (cnt == '0);
  assign do_pop = pop && !empty;
  assign dout   = mem[rd_ptr];
  assign count  = cnt;

  always_ff @(posedge vclk) begin
    if (srst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge vclk) begin
    if (push && !flush && !srst)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vga_pixel_prefetch.sv
// Prefetches one frame of pixels from memory into a small FIFO ahead of the
// timing generator, with credit-based request throttling and stale-response discard.
module vga_pixel_prefetch
  import vga_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 20
) (
  input  logic                 vclk,
  input  logic                 srst,
  input  logic [9:0]           width,
  input  logic [9:0]           height,
  input  logic [BIT_DEPTH-1:0] clear,
  input  logic                 resync,
  input  logic                 pop,
  output logic [BIT_DEPTH-1:0] pixel,
  output logic                 mem_req,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic                 mem_ack,
  input  logic                 mem_rvalid,
  input  logic [BIT_DEPTH-1:0] mem_rdata,
  output logic                 underflow
);
  localparam int CW = $clog2(DEPTH) + 1;

  vga_state_e           state;
  logic [9:0]           w_r;
  logic [9:0]           h_r;
  logic [9:0]           x_cnt;
  logic [9:0]           y_cnt;
  logic [ADDR_W-1:0]    addr_r;
  logic [CW-1:0]        outstanding;
  logic [CW-1:0]        discard;
  logic [CW-1:0]        fifo_count;
  logic [CW-1:0]        used;
  logic [BIT_DEPTH-1:0] fifo_dout;
  logic                 fifo_empty;
  logic                 accept;
  logic                 rsp_keep;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 underflow_r;

  // Stale responses still in flight occupy credit too, so the total never exceeds DEPTH.
  assign used      = fifo_count + outstanding + discard;
  assign mem_req   = (state == FETCH) && (used < CW'(DEPTH));
  assign mem_addr  = addr_r;
  assign accept    = mem_req && mem_ack;
  assign rsp_keep  = mem_rvalid && (discard == '0);
  assign fifo_push = rsp_keep && !resync;
  assign fifo_pop  = pop && !resync;
  assign pixel     = fifo_empty ? clear : fifo_dout;
  assign underflow = underflow_r;

  vga_pixel_fifo #(
    .BIT_DEPTH (BIT_DEPTH),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .vclk  (vclk),
    .srst  (srst),
    .flush (resync),
    .push  (fifo_push),
    .din   (mem_rdata),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  always_ff @(posedge vclk) begin
    if (srst) begin
      state  <= IDLE;
      w_r    <= '0;
      h_r    <= '0;
      x_cnt  <= '0;
      y_cnt  <= '0;
      addr_r <= '0;
    end else if (resync) begin
      w_r    <= width;
      h_r    <= height;
      x_cnt  <= '0;
      y_cnt  <= '0;
      addr_r <= '0;
      state  <= (width == '0 || height == '0) ? DONE : FETCH;
    end else if (accept) begin
      addr_r <= addr_r + ADDR_W'(1);
      if (x_cnt == w_r - 10'd1) begin
        x_cnt <= '0;
        if (y_cnt == h_r - 10'd1)
          state <= DONE;
        else
          y_cnt <= y_cnt + 10'd1;
      end else begin
        x_cnt <= x_cnt + 10'd1;
      end
    end
  end

  // On resync everything still in flight, including this cycle's accept, becomes discard.
  always_ff @(posedge vclk) begin
    if (srst) begin
      outstanding <= '0;
      discard     <= '0;
    end else if (resync) begin
      outstanding <= '0;
      discard     <= discard + outstanding + CW'(accept) - CW'(mem_rvalid);
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(rsp_keep);
      if (mem_rvalid && discard != '0)
        discard <= discard - CW'(1);
    end
  end

  always_ff @(posedge vclk) begin
    if (srst)
      underflow_r <= 1'b0;
    else if (pop && fifo_empty)
      underflow_r <= 1'b1;
  end

endmodule

// File: tb/tb_vga_pixel_prefetch.sv
// Scoreboard bench for vga_pixel_prefetch: randomized memory latency/ack against
// an epoch-tagged frame model.
module tb_vga_pixel_prefetch;
  localparam int BD = 8;
  localparam int DP = 16;
  localparam int AW = 20;

  logic          vclk = 1'b0;
  logic          srst = 1'b1;
  logic [9:0]    width = '0;
  logic [9:0]    height = '0;
  logic [BD-1:0] clear = 8'h3C;
  logic          resync = 1'b0;
  logic          pop = 1'b0;
  logic [BD-1:0] pixel;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [BD-1:0] mem_rdata = '0;
  logic          underflow;

  always #5 vclk = ~vclk;

  vga_pixel_prefetch #(.BIT_DEPTH(BD), .DEPTH(DP), .ADDR_W(AW)) dut (
    .vclk       (vclk),
    .srst       (srst),
    .width      (width),
    .height     (height),
    .clear      (clear),
    .resync     (resync),
    .pop        (pop),
    .pixel      (pixel),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .underflow  (underflow)
  );

  typedef struct { int addr; int ep; int due; } beat_t;

  beat_t         mem_q[$];
  int            exp_addr[$];
  logic [BD-1:0] pix_q[$];
  int  epoch = 0, cyc = 0, next_pix = 0, req_count = 0;
  int  lat_min = 3, lat_max = 3, ack_mode = 1;
  bit  uf_m = 0;
  bit  beat_v = 0;
  int  beat_ep = 0;
  bit  prev_stall = 0, prev_resync = 0;
  logic [AW-1:0] prev_addr = '0;
  int  n_tests = 0, n_fail = 0;

  function automatic logic [BD-1:0] dval(int a, int e);
    return BD'(a * 29 + e * 71 + 13);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory: in-order responses, per-beat random latency, ack policy 0/1/random.
  always @(posedge vclk) begin
    cyc++;
    #1;
    mem_ack = (ack_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(ack_mode);
    mem_rvalid = 1'b0;
    beat_v = 0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      beat_t b;
      b = mem_q.pop_front();
      mem_rvalid = 1'b1;
      mem_rdata  = dval(b.addr, b.ep);
      beat_v     = 1;
      beat_ep    = b.ep;
    end
  end

  // Monitor: check outputs, then advance the model across the coming edge.
  always @(negedge vclk) begin
    if (srst) begin
      mem_q.delete();
      exp_addr.delete();
      pix_q.delete();
      uf_m = 0;
      epoch++;
      prev_stall = 0;
    end else begin
      chk("pixel", pixel, (pix_q.size() > 0) ? pix_q[0] : clear);
      chk("underflow", underflow, uf_m);
      if (mem_req) begin
        chk("req_when_fetching", exp_addr.size() > 0, 1);
        chk("req_credit", (pix_q.size() + mem_q.size() + int'(beat_v)) < DP, 1);
        if (exp_addr.size() > 0) chk("mem_addr", mem_addr, exp_addr[0]);
      end
      if (prev_stall && !prev_resync) begin
        chk("hold_req", mem_req, 1);
        chk("hold_addr", mem_addr, prev_addr);
      end
      prev_stall  = mem_req && !mem_ack;
      prev_addr   = mem_addr;
      prev_resync = resync;
      if (mem_req && mem_ack) begin
        mem_q.push_back('{int'(mem_addr), epoch, cyc + $urandom_range(lat_min, lat_max)});
        if (exp_addr.size() > 0) void'(exp_addr.pop_front());
        req_count++;
      end
      if (pop) begin
        if (pix_q.size() == 0) uf_m = 1;
        else if (!resync) void'(pix_q.pop_front());
      end
      if (beat_v && beat_ep == epoch && !resync) begin
        pix_q.push_back(dval(next_pix, epoch));
        next_pix++;
      end
      if (resync) begin
        epoch++;
        pix_q.delete();
        exp_addr.delete();
        for (int i = 0; i < int'(width) * int'(height); i++) exp_addr.push_back(i);
        next_pix = 0;
      end
    end
  end

  task automatic tick();
    @(posedge vclk);
    #1;
  endtask

  task automatic do_resync(int w, int h);
    width  = 10'(w);
    height = 10'(h);
    resync = 1'b1;
    tick();
    resync = 1'b0;
  endtask

  task automatic wait_filled(string nm, int n);
    int i;
    for (i = 0; i < 500 && !(pix_q.size() == n && mem_q.size() == 0); i++) tick();
    chk(nm, pix_q.size() == n && mem_q.size() == 0, 1);
  endtask

  task automatic pop_n(int n);
    pop = 1'b1;
    repeat (n) tick();
    pop = 1'b0;
  endtask

  initial begin
    int pops_done;
    int stale;
    tick();
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_pixel", pixel, 8'h3C);
    chk("rst_underflow", underflow, 0);
    tick();
    srst = 1'b0;
    tick();

    // 4x2 frame, latency 3, ack tied high
    ack_mode = 1; lat_min = 3; lat_max = 3;
    req_count = 0;
    do_resync(4, 2);
    wait_filled("s1_fill", 8);
    chk("s1_req_count", req_count, 8);
    pop_n(8);
    chk("s1_drained", pix_q.size(), 0);
    chk("s1_underflow", underflow, 0);

    // Back-pressure: pop low, random ack and latency
    ack_mode = 2; lat_min = 1; lat_max = 5;
    req_count = 0;
    do_resync(64, 4);
    repeat (300) tick();
    chk("s2_fifo_full", pix_q.size(), DP);
    chk("s2_no_inflight", mem_q.size(), 0);
    chk("s2_req_low", mem_req, 0);
    chk("s2_req_count", req_count, DP);
    pops_done = 0;
    for (int i = 0; i < 5000 && pops_done < 256; i++) begin
      pop = (pix_q.size() > 0) && ($urandom_range(0, 1) == 1);
      if (pop) pops_done++;
      tick();
    end
    pop = 1'b0;
    chk("s2_all_popped", pops_done, 256);
    chk("s2_underflow", underflow, 0);

    // Resync with requests in flight: stale beats must be dropped
    ack_mode = 1; lat_min = 4; lat_max = 4;
    do_resync(64, 4);
    for (int i = 0; i < 20 && mem_q.size() < 3; i++) tick();
    stale = mem_q.size();
    chk("s3_inflight", stale >= 3, 1);
    do_resync(4, 2);
    wait_filled("s3_refill", 8);
    chk("s3_first_pixel", pixel, dval(0, epoch));
    pop_n(8);

    // Underflow on empty FIFO
    clear = 8'hA5;
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("s4_pixel_clear", pixel, 8'hA5);
    chk("s4_underflow_set", underflow, 1);
    repeat (10) tick();
    do_resync(4, 2);
    repeat (5) tick();
    chk("s4_underflow_sticky", underflow, 1);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    tick();
    chk("s4_underflow_cleared", underflow, 0);

    // Zero width: straight to DONE, never requests
    req_count = 0;
    do_resync(0, 5);
    repeat (30) tick();
    chk("s5_no_requests", req_count, 0);
    chk("s5_req_low", mem_req, 0);

    // srst mid-fetch with ack low
    ack_mode = 0;
    do_resync(64, 4);
    repeat (5) tick();
    chk("s6_req_pending", mem_req, 1);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    chk("s6_req_after_rst", mem_req, 0);
    chk("s6_pixel_after_rst", pixel, 8'hA5);
    chk("s6_addr_after_rst", mem_addr, 0);
    ack_mode = 1;
    req_count = 0;
    repeat (10) tick();
    chk("s6_idle_no_req", req_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pixel_prefetch.md
VGA_PIXEL_PREFETCH -- requirements
Module: vga_pixel_prefetch

Interface
REQ-001 SHALL have parameter BIT_DEPTH, default 8, meaning pixel width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, meaning pixel FIFO entries; power of two, at least 4.
REQ-003 SHALL have parameter ADDR_W, default 20, meaning memory word address width.
REQ-004 SHALL have port vclk, input, 1 bit: clock; all logic on its rising edge.
REQ-005 SHALL have port srst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have ports width and height, input, 10 bits each: frame size in pixels.
REQ-007 SHALL have port clear, input, BIT_DEPTH bits: colour shown on underflow.
REQ-008 SHALL have port resync, input, 1 bit: one-cycle start-of-new-frame-fetch pulse, driven from the timing generator's frame_end.
REQ-009 SHALL have port pop, input, 1 bit: timing generator consumes the current pixel this cycle.
REQ-010 SHALL have port pixel, output, BIT_DEPTH bits: FIFO head, or clear when the FIFO is empty.
REQ-011 SHALL have ports mem_req (output, 1), mem_addr (output, ADDR_W) and mem_ack (input, 1): read request; transfers when mem_req and mem_ack are both high.
REQ-012 SHALL have ports mem_rvalid (input, 1) and mem_rdata (input, BIT_DEPTH): in-order read responses, any latency of 1 cycle or more, no back-pressure.
REQ-013 SHALL have port underflow, output, 1 bit: sticky flag set by pop while empty.

Function
REQ-014 SHALL implement FSM IDLE -> FETCH on resync; FETCH -> DONE when the last address (width*height-1) is accepted; DONE/FETCH -> FETCH on resync.
REQ-015 SHALL sample width and height on resync; a 0 in either value goes directly to DONE.
REQ-016 SHALL generate addresses with x/y fetch counters and a running address that increments by 1 per accepted request, with no multiplier; the address starts at 0 on resync.
REQ-017 SHALL assert mem_req only in FETCH and only when fifo_count + outstanding < DEPTH (credit rule), so the FIFO never overflows.
REQ-018 SHALL hold mem_addr stable while mem_req is high and mem_ack is low.
REQ-019 SHALL write mem_rdata into the FIFO on mem_rvalid, unless discarded (REQ-022).
REQ-020 SHALL make pixel combinational from the FIFO head (first-word fall-through); pop on non-empty removes the head the same cycle.
REQ-021 SHALL, on pop while empty: leave the FIFO unchanged, drive pixel = clear, and set underflow until srst.
REQ-022 SHALL, on resync: flush the FIFO and set discard = outstanding responses; later mem_rvalid beats decrement discard and are dropped until it reaches 0.
REQ-023 SHALL keep the FIFO count unchanged on a simultaneous push and pop; pop on a one-entry FIFO with a simultaneous push leaves the new word as head.
REQ-024 SHALL give resync priority over pop, push and request acceptance in the same cycle; a request accepted in that cycle is counted as outstanding and discarded.
REQ-025 SHALL size the outstanding and discard counters to hold DEPTH without wrapping.

Reset
REQ-026 SHALL, on srst: state=IDLE, mem_req=0, mem_addr=0, FIFO empty, outstanding=0, discard=0, underflow=0, pixel=clear.
REQ-027 SHALL require that srst is shared with the memory, so no responses arrive for requests made before reset.
REQ-028 SHALL let srst override resync and all other inputs.

Structure
REQ-029 SHALL place the FSM state enum (IDLE, FETCH, DONE) in shared package vga_pkg.
REQ-030 SHALL implement the FIFO as sub-module vga_pixel_fifo (fall-through, count output, synchronous flush).

Verification
REQ-031 SHALL cover: width=4, height=2, mem latency 3, mem_ack tied high, resync, then pop on every cycle after the FIFO is full -> addresses 0..7 issued once each, pixels returned in order, underflow=0.
REQ-032 SHALL cover: DEPTH=16, pop held low -> mem_req drops with exactly 16 entries+outstanding, and no response is lost.
REQ-033 SHALL cover: pop on an empty FIFO with clear=8'hA5 -> pixel=8'hA5, underflow=1 and stays 1 until srst.
REQ-034 SHALL cover: resync with 3 outstanding requests -> the next 3 mem_rvalid beats are dropped, the FIFO refills starting at address 0.
REQ-035 SHALL cover: width=0 on resync -> state DONE, mem_req never asserts.
REQ-036 SHALL cover: srst mid-FETCH with mem_ack low -> mem_req=0, FIFO empty, state IDLE the next cycle.
